// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: branch redirect with one delay slot, load-use bubbles, imem waits, halt/resume.
// Define FETCH_CTRL_PERF_EN to add stall_cnt_o / flush_cnt_o event counters.
module fetch_ctrl #(
    parameter int PC_W  = 32,
    parameter int REG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             br_taken_i,
    input  logic [PC_W-1:0]  br_target_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             imem_ready_i,
    input  logic             halt_req_i,
    input  logic             resume_i,
    output logic             mux_pc_sel_o,
    output logic [PC_W-1:0]  mux_pc_o,
    output logic             stall_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic [1:0]       state_o
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_cnt_o,
    output logic [31:0]      flush_cnt_o
`endif
);

    // state    | meaning
    // RUN      | normal fetch; load-use and imem-wait bubbles applied here
    // REDIRECT | one cycle: PC takes latched target, wrong-path fetches killed
    // HALT     | fetch frozen until resume_i
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] REDIRECT = 2'd1;
    localparam logic [1:0] HALT     = 2'd2;

    logic [1:0]      state_q,   state_d;
    logic [PC_W-1:0] mux_pc_q,  mux_pc_d;
    logic            ds_held_q, ds_held_d;
    logic            lu;

    assign lu = ex_memread_i && (ex_rt_i != '0) &&
                ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

    always_comb begin
        state_d      = state_q;
        mux_pc_d     = mux_pc_q;
        ds_held_d    = ds_held_q;
        mux_pc_sel_o = 1'b0;
        stall_o      = 1'b0;
        ifid_flush_o = 1'b0;
        idex_flush_o = 1'b0;
        case (state_q)
            RUN: begin
                if (lu) begin
                    stall_o      = 1'b1;
                    idex_flush_o = 1'b1;
                end else if (!imem_ready_i) begin
                    stall_o      = 1'b1;
                    ifid_flush_o = 1'b1;
                end
                // Branch is taken regardless of bubbles; a stalled delay slot is remembered.
                if (br_taken_i) begin
                    mux_pc_d  = br_target_i;
                    ds_held_d = lu;
                    state_d   = REDIRECT;
                end else if (halt_req_i) begin
                    state_d = HALT;
                end
            end
            REDIRECT: begin
                mux_pc_sel_o = 1'b1;
                ifid_flush_o = 1'b1;
                idex_flush_o = !ds_held_q;
                state_d      = halt_req_i ? HALT : RUN;
            end
            HALT: begin
                stall_o      = 1'b1;
                idex_flush_o = 1'b1;
                if (resume_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= RUN;
            mux_pc_q  <= '0;
            ds_held_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mux_pc_q  <= mux_pc_d;
            ds_held_q <= ds_held_d;
        end
    end

    assign mux_pc_o = mux_pc_q;
    assign state_o  = state_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_o)                      stall_cnt_d = stall_cnt_q + 32'd1;
        if (ifid_flush_o || idex_flush_o) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the fetch stage. Each cycle it drives the fetch stage's next-PC select, next-PC value and stall input, plus the IF/ID and ID/EX flush strobes. It serialises four events: taken-branch/jump redirects with one architectural delay slot, load-use bubbles, instruction-memory wait states, and an external halt/resume. It sits beside the hazard logic in the pipeline top and is the only driver of the fetch stage's control inputs.

## Interface
- PC_W, 32, width of PC and branch target
- REG_W, 5, register-specifier width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- br_taken_i  in  1  taken branch/jump resolved in EX this cycle
- br_target_i  in  PC_W  target address, valid with br_taken_i
- ex_memread_i  in  1  instruction in EX is a load
- ex_rt_i  in  REG_W  load destination in EX
- id_rs_i, id_rt_i  in  REG_W  source specifiers of instruction in ID
- imem_ready_i  in  1  instruction memory returns valid data this cycle
- halt_req_i  in  1  level request to freeze fetch
- resume_i  in  1  one-cycle pulse to leave HALT
- mux_pc_sel_o  out  1  1 = next PC is mux_pc_o, 0 = PC+4
- mux_pc_o  out  PC_W  registered redirect target
- stall_o  out  1  hold PC and IF/ID
- ifid_flush_o  out  1  write bubble into IF/ID
- idex_flush_o  out  1  write bubble into ID/EX
- state_o  out  2  RUN=0, REDIRECT=1, HALT=2

## Operation
- States: RUN, REDIRECT, HALT. Reset enters RUN.
- Load-use detect (lu) is asserted when ex_memread_i & ex_rt_i!=0 & (ex_rt_i==id_rs_i | ex_rt_i==id_rt_i).
- RUN, priority order:
  - lu: stall_o=1, idex_flush_o=1 (combinational, same cycle).
  - else !imem_ready_i: stall_o=1, ifid_flush_o=1.
  - br_taken_i is evaluated independently of the above. It latches br_target_i into mux_pc_o and a ds_held flag (=lu this cycle), then goes to REDIRECT.
  - else halt_req_i goes to HALT.
- REDIRECT (exactly 1 cycle):
  - mux_pc_sel_o=1, stall_o=0, ifid_flush_o=1.
  - idex_flush_o=!ds_held. When the delay slot was stalled it still sits in ID and must survive.
  - imem_ready_i and lu are ignored.
  - Next state is HALT if halt_req_i, else RUN.
- HALT:
  - stall_o=1, idex_flush_o=1 every cycle.
  - resume_i returns to RUN the next cycle.
  - br_taken_i is ignored; the pipeline is drained.
- mux_pc_o holds its last latched value outside REDIRECT.
- All flush/stall outputs are 0 in RUN when no condition applies.

## Timing
- Reset (rst_i low, async): state=RUN, mux_pc_o=0, ds_held=0, all 1-bit outputs 0.
- Outputs are combinational from state plus registered flags plus lu/imem_ready_i. There are no input-to-output paths through br_taken_i.
- Branch resolved in EX at cycle t: the delay slot (fetched t-1) proceeds. Instructions fetched at t and t+1 are killed at t+1. The PC loads the target at the end of t+1. The first target instruction is in IF at t+2.
- Redirect penalty: 2 bubbles, plus 1 if lu coincided at t.
- Simultaneous br_taken_i and halt_req_i: REDIRECT first, then HALT.
- Simultaneous halt_req_i and lu in RUN: lu bubble this cycle, HALT next.
- Reset asserted mid-REDIRECT: the redirect is abandoned and the PC is owned by the fetch reset.

## Configuration
- FETCH_CTRL_PERF_EN defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0], both reset to 0.
  - stall_cnt_o increments each cycle stall_o=1.
  - flush_cnt_o increments each cycle ifid_flush_o|idex_flush_o=1.
  - Both wrap 0xFFFFFFFF→0.
- Undefined: ports and counters are absent. Control behaviour is identical.

## Test plan
- Reset release, no events: mux_pc_sel_o=0, stall_o=0, both flushes 0, state_o=0 for 10 cycles.
- ex_memread_i=1, ex_rt_i=8, id_rs_i=8 for one cycle: stall_o=1, idex_flush_o=1 that cycle only. ex_rt_i=0 with id_rs_i=0: no stall.
- br_taken_i=1, br_target_i=0x00400040 at cycle t: at t+1 mux_pc_sel_o=1, mux_pc_o=0x00400040, ifid_flush_o=1, idex_flush_o=1. At t+2 back in RUN.
- br_taken_i and load-use hazard both at t: at t stall_o=1, idex_flush_o=1. At t+1 ifid_flush_o=1, idex_flush_o=0, mux_pc_sel_o=1.
- imem_ready_i=0 for 3 cycles in RUN: stall_o=1, ifid_flush_o=1 for exactly 3 cycles. In REDIRECT with imem_ready_i=0: stall_o=0.
- halt_req_i high for 5 cycles, resume_i pulse at cycle 8: state_o=2 with stall_o=1 from cycle 1 to 8, RUN at cycle 9. With FETCH_CTRL_PERF_EN, stall_cnt_o=8.
